// File: rtl/vect_result_writer.sv
// ---------------------------------------------------------------------------
// vect_result_writer
//
// Writeback serializer for the vector ALU result bus. One packed vector of
// M lanes (N bits each) is captured together with a lane-enable mask and a
// base word address. Each enabled lane is then emitted, lowest index first,
// as a scalar write beat on a valid/ready memory port at address
// base + lane index (wrapping modulo 2^ADDR_W). Disabled lanes cost no cycles.
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   packed vector offered
//   o_in_ready   block idle, vector will be accepted
//   i_in_data    packed vector, lane i = i_in_data[N*i +: N]
//   i_in_mask    lane enables, bit i set = write lane i
//   i_in_base    word address of lane 0
//   o_out_valid  write beat presented
//   i_out_ready  memory accepts the beat
//   o_out_addr   write address of the current beat
//   o_out_data   lane value of the current beat
//   o_out_lane   lane index of the current beat
//   o_busy       transaction in progress
//   o_done       one-cycle pulse when the transaction ends
// ---------------------------------------------------------------------------
module vect_result_writer #(
    parameter int N      = 24,
    parameter int M      = 6,
    parameter int ADDR_W = 16,
    parameter int LANE_W = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [N*M-1:0]      i_in_data,
    input  logic [M-1:0]        i_in_mask,
    input  logic [ADDR_W-1:0]   i_in_base,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [ADDR_W-1:0]   o_out_addr,
    output logic [N-1:0]        o_out_data,
    output logic [LANE_W-1:0]   o_out_lane,
    output logic                o_busy,
    output logic                o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [N*M-1:0]      r_data;
    logic [M-1:0]        r_pending;
    logic [ADDR_W-1:0]   r_base;

    logic [LANE_W-1:0]   w_lane;
    logic [M-1:0]        w_laneOneHot;
    logic [N-1:0]        w_laneData;
    logic [M-1:0]        w_remaining;
    logic                w_accept;
    logic                w_fire;

    // Priority encoder over the pending mask: the descending loop lets the
    // lowest set bit win, which gives the ascending emission order. The lane
    // data is picked with constant slices so no variable part-select is needed.
    always_comb begin
        w_lane       = '0;
        w_laneOneHot = '0;
        w_laneData   = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_lane          = LANE_W'(i);
                w_laneOneHot    = '0;
                w_laneOneHot[i] = 1'b1;
                w_laneData      = r_data[i*N +: N];
            end
        end
    end

    assign w_accept    = (r_state == IDLE) && i_in_valid;
    assign w_fire      = (r_state == SEND) && i_out_ready;
    assign w_remaining = r_pending & ~w_laneOneHot;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. An empty mask skips SEND entirely so the done pulse
    // follows the accept directly; SEND leaves on the handshake of the last
    // pending lane.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (i_in_valid) begin
                    w_nextState = (|i_in_mask) ? SEND : FIN;
                end
            end
            SEND: begin
                if (w_fire && (w_remaining == '0)) begin
                    w_nextState = FIN;
                end
            end
            FIN: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Private copy of the vector. The pending mask only changes on a
    // handshake, which is what keeps the presented beat stable under stall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data    <= '0;
            r_pending <= '0;
            r_base    <= '0;
        end else if (w_accept) begin
            r_data    <= i_in_data;
            r_pending <= i_in_mask;
            r_base    <= i_in_base;
        end else if (w_fire) begin
            r_pending <= w_remaining;
        end
    end

    // Outputs decode from the state and the registered datapath only. Beat
    // fields are forced to zero outside SEND so they read as zero in reset.
    always_comb begin
        o_in_ready  = (r_state == IDLE);
        o_busy      = (r_state != IDLE);
        o_done      = (r_state == FIN);
        o_out_valid = (r_state == SEND);
        o_out_data  = '0;
        o_out_addr  = '0;
        o_out_lane  = '0;
        if (r_state == SEND) begin
            o_out_data = w_laneData;
            o_out_addr = r_base + ADDR_W'(w_lane);
            o_out_lane = w_lane;
        end
    end

endmodule

// File: tb/tb_vect_result_writer.sv
// ---------------------------------------------------------------------------
// tb_vect_result_writer
//
// Scenario bench for vect_result_writer. Expected write beats are queued when
// a vector is driven and compared by a negedge monitor as each handshake
// happens; the scenario tasks check timing, counts and stall stability.
// ---------------------------------------------------------------------------
module tb_vect_result_writer;

    localparam int N      = 24;
    localparam int M      = 6;
    localparam int ADDR_W = 16;
    localparam int LANE_W = 3;

    logic                clk = 1'b0;
    logic                rstN;
    logic                inValid;
    logic                inReady;
    logic [N*M-1:0]      inData;
    logic [M-1:0]        inMask;
    logic [ADDR_W-1:0]   inBase;
    logic                outValid;
    logic                outReady;
    logic [ADDR_W-1:0]   outAddr;
    logic [N-1:0]        outData;
    logic [LANE_W-1:0]   outLane;
    logic                busy;
    logic                done;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [N-1:0]      data;
        logic [LANE_W-1:0] lane;
    } beat_t;

    beat_t expQ[$];
    beat_t monExp;

    int checks      = 0;
    int failures    = 0;
    int cycleCnt    = 0;
    int acceptCount = 0;
    int beatCount   = 0;
    int doneCount   = 0;
    int acceptCyc   = 0;
    int doneCyc     = 0;

    logic [N*M-1:0] stdVector;

    vect_result_writer #(
        .N(N), .M(M), .ADDR_W(ADDR_W), .LANE_W(LANE_W)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_in_valid  (inValid),
        .o_in_ready  (inReady),
        .i_in_data   (inData),
        .i_in_mask   (inMask),
        .i_in_base   (inBase),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_out_addr  (outAddr),
        .o_out_data  (outData),
        .o_out_lane  (outLane),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    // Monitor: records accepts and done pulses, and scores every handshake
    // against the head of the expected-beat queue.
    always @(negedge clk) begin
        if (rstN) begin
            if (inValid && inReady) begin
                acceptCount++;
                acceptCyc = cycleCnt;
            end
            if (outValid && outReady) begin
                beatCount++;
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL scoreboard_extra_beat: got lane=%0d addr=%h data=%0d, required no beat",
                             outLane, outAddr, outData);
                end else begin
                    monExp = expQ.pop_front();
                    if (outAddr !== monExp.addr || outData !== monExp.data || outLane !== monExp.lane) begin
                        failures++;
                        $display("[TB] FAIL scoreboard_beat: got lane=%0d addr=%h data=%0d, required lane=%0d addr=%h data=%0d",
                                 outLane, outAddr, outData, monExp.lane, monExp.addr, monExp.data);
                    end
                end
            end
            if (done) begin
                doneCount++;
                doneCyc = cycleCnt;
            end
        end
    end

    // Queue the expected beats for a vector: enabled lanes, ascending, with
    // the address wrapping at the address width.
    task automatic pushExpected(input logic [N*M-1:0] data, input logic [M-1:0] mask,
                                input logic [ADDR_W-1:0] base);
        beat_t b;
        for (int i = 0; i < M; i++) begin
            if (mask[i]) begin
                b.addr = base + ADDR_W'(i);
                b.data = data[i*N +: N];
                b.lane = LANE_W'(i);
                expQ.push_back(b);
            end
        end
    endtask

    // Offer one vector for a single cycle; the block is idle when called.
    task automatic applyStimulus(input logic [N*M-1:0] data, input logic [M-1:0] mask,
                                 input logic [ADDR_W-1:0] base);
        pushExpected(data, mask, base);
        @(posedge clk); #1;
        inValid = 1'b1;
        inData  = data;
        inMask  = mask;
        inBase  = base;
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    // Bounded wait for the next done pulse after startDone pulses were seen.
    task automatic waitDone(input int startDone, input int maxCycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge clk); #1;
            if (doneCount != startDone) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        #12;
        checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got ready=%b valid=%b busy=%b done=%b, required 1 0 0 0",
                     inReady, outValid, busy, done);
        end
        checks++;
        if (outData !== '0 || outAddr !== '0 || outLane !== '0) begin
            failures++;
            $display("[TB] FAIL reset_beat: got data=%0d addr=%h lane=%0d, required 0 0 0",
                     outData, outAddr, outLane);
        end
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_mask();
        int  startDone  = doneCount;
        int  startBeats = beatCount;
        bit  ok;
        applyStimulus(stdVector, 6'b111111, 16'h0100);
        waitDone(startDone, 40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL full_done_timeout: got no done, required done");
        end
        checks++;
        if (doneCyc - acceptCyc !== 7) begin
            failures++;
            $display("[TB] FAIL full_latency: got %0d, required 7", doneCyc - acceptCyc);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (beatCount - startBeats !== 6 || doneCount - startDone !== 1 || expQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL full_counts: got beats=%0d dones=%0d left=%0d, required 6 1 0",
                     beatCount - startBeats, doneCount - startDone, expQ.size());
        end
    endtask

    task automatic test_sparse_mask();
        int  startDone  = doneCount;
        int  startBeats = beatCount;
        bit  ok;
        applyStimulus(stdVector, 6'b100101, 16'h0100);
        waitDone(startDone, 40, ok);
        checks++;
        if (!ok || doneCyc - acceptCyc !== 4) begin
            failures++;
            $display("[TB] FAIL sparse_latency: got done=%0b latency=%0d, required 1 4", ok, doneCyc - acceptCyc);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (beatCount - startBeats !== 3 || expQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL sparse_counts: got beats=%0d left=%0d, required 3 0",
                     beatCount - startBeats, expQ.size());
        end
    endtask

    task automatic test_backpressure();
        int  startDone  = doneCount;
        int  startBeats = beatCount;
        bit  ok;
        bit  stalled = 1'b0;
        applyStimulus(stdVector, 6'b111111, 16'h0100);
        for (int c = 0; c < 10 && !stalled; c++) begin
            if (outValid && outLane == 3'd2) begin
                stalled  = 1'b1;
                outReady = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (outValid !== 1'b1 || outData !== 24'd33 || outAddr !== 16'h0102 || outLane !== 3'd2) begin
                        failures++;
                        $display("[TB] FAIL stall_hold: got valid=%b data=%0d addr=%h lane=%0d, required 1 33 0102 2",
                                 outValid, outData, outAddr, outLane);
                    end
                end
                outReady = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!stalled) begin
            failures++;
            $display("[TB] FAIL stall_lane2_seen: got no lane-2 beat, required lane-2 beat");
        end
        waitDone(startDone, 40, ok);
        checks++;
        if (!ok || doneCyc - acceptCyc !== 10) begin
            failures++;
            $display("[TB] FAIL stall_latency: got done=%0b latency=%0d, required 1 10", ok, doneCyc - acceptCyc);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (beatCount - startBeats !== 6 || expQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL stall_counts: got beats=%0d left=%0d, required 6 0",
                     beatCount - startBeats, expQ.size());
        end
    endtask

    task automatic test_zero_and_wrap();
        int  startDone  = doneCount;
        int  startBeats = beatCount;
        bit  ok;
        applyStimulus(stdVector, 6'b000000, 16'h0200);
        waitDone(startDone, 10, ok);
        checks++;
        if (!ok || doneCyc - acceptCyc !== 1 || beatCount !== startBeats) begin
            failures++;
            $display("[TB] FAIL zero_mask: got done=%0b latency=%0d beats=%0d, required 1 1 0",
                     ok, doneCyc - acceptCyc, beatCount - startBeats);
        end
        startDone  = doneCount;
        startBeats = beatCount;
        applyStimulus(stdVector, 6'b000111, 16'hFFFE);
        waitDone(startDone, 20, ok);
        checks++;
        if (!ok || doneCyc - acceptCyc !== 4) begin
            failures++;
            $display("[TB] FAIL wrap_latency: got done=%0b latency=%0d, required 1 4", ok, doneCyc - acceptCyc);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (beatCount - startBeats !== 3 || expQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL wrap_counts: got beats=%0d left=%0d, required 3 0",
                     beatCount - startBeats, expQ.size());
        end
    endtask

    task automatic test_reset_mid();
        int  startDone  = doneCount;
        int  startBeats = beatCount;
        int  heldDone;
        bit  ok;
        bit  reached = 1'b0;
        applyStimulus(stdVector, 6'b111111, 16'h0100);
        for (int c = 0; c < 20 && !reached; c++) begin
            @(negedge clk); #1;
            if (beatCount - startBeats >= 2) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            failures++;
            $display("[TB] FAIL rstmid_lane1_seen: got %0d beats, required 2", beatCount - startBeats);
        end
        @(posedge clk); #2;
        rstN = 1'b0;
        #1;
        checks++;
        if (outValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || inReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_drop: got valid=%b busy=%b done=%b ready=%b, required 0 0 0 1",
                     outValid, busy, done, inReady);
        end
        expQ.delete();
        heldDone = doneCount;
        @(posedge clk); #1;
        rstN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (doneCount !== heldDone || doneCount !== startDone) begin
            failures++;
            $display("[TB] FAIL rstmid_no_done: got %0d done pulses, required 0", doneCount - startDone);
        end
        startDone  = doneCount;
        startBeats = beatCount;
        applyStimulus(stdVector, 6'b111111, 16'h0400);
        waitDone(startDone, 40, ok);
        checks++;
        if (!ok || doneCyc - acceptCyc !== 7) begin
            failures++;
            $display("[TB] FAIL rstmid_recover: got done=%0b latency=%0d, required 1 7", ok, doneCyc - acceptCyc);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (beatCount - startBeats !== 6 || expQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL rstmid_counts: got beats=%0d left=%0d, required 6 0",
                     beatCount - startBeats, expQ.size());
        end
    endtask

    task automatic test_input_isolation();
        int  startDone   = doneCount;
        int  startBeats  = beatCount;
        int  startAccept = acceptCount;
        bit  ok;
        pushExpected(stdVector, 6'b011011, 16'h0300);
        @(posedge clk); #1;
        inValid = 1'b1;
        inData  = stdVector;
        inMask  = 6'b011011;
        inBase  = 16'h0300;
        @(posedge clk); #1;
        inData  = {M{24'hABCDEF}};
        inMask  = 6'b111111;
        inBase  = 16'h0500;
        waitDone(startDone, 30, ok);
        checks++;
        if (!ok || acceptCount - startAccept !== 1) begin
            failures++;
            $display("[TB] FAIL iso_single_accept: got done=%0b accepts=%0d, required 1 1",
                     ok, acceptCount - startAccept);
        end
        inValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (acceptCount - startAccept !== 1 || beatCount - startBeats !== 4 || expQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL iso_counts: got accepts=%0d beats=%0d left=%0d, required 1 4 0",
                     acceptCount - startAccept, beatCount - startBeats, expQ.size());
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] laneVals [M];
        laneVals = '{24'd12, 24'd45, 24'd33, 24'd98, 24'd86, 24'd52};
        for (int i = 0; i < M; i++) stdVector[i*N +: N] = laneVals[i];
        inValid  = 1'b0;
        inData   = '0;
        inMask   = '0;
        inBase   = '0;
        outReady = 1'b1;

        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_backpressure();
        test_zero_and_wrap();
        test_reset_mid();
        test_input_isolation();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
